// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC datapath and its controlling FSM.
// Angles are in Q2.14 radians, so 1.0 rad = 16384.
package cordic_pkg;

   localparam int CORDIC_W      = 16;
   localparam int CORDIC_N_ITER = 8;

   // The FSM drives in_mux_ctl with exactly these codes.
   typedef enum logic [1:0] {
      MUX_HOLD = 2'b00,
      MUX_LOAD = 2'b01,
      MUX_ITER = 2'b10,
      MUX_CLR  = 2'b11
   } cordic_mux_e;

   // atan(2^-i) in Q2.14, for i = 0 .. 7
   function automatic logic [15:0] cordic_atan(input logic [2:0] idx);
      logic [15:0] val;
      case (idx)
         3'd0:    val = 16'd12868;
         3'd1:    val = 16'd7596;
         3'd2:    val = 16'd4014;
         3'd3:    val = 16'd2037;
         3'd4:    val = 16'd1023;
         3'd5:    val = 16'd512;
         3'd6:    val = 16'd256;
         default: val = 16'd128;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// Saturating iteration counter; counter_rst beats counter_hold beats increment.
// It stops at N_ITER so the FSM sees a stable terminal value.
module cordic_iter_counter
   import cordic_pkg::*;
#(
   parameter int N_ITER = CORDIC_N_ITER
) (
   input  logic       clka,
   input  logic       reset,
   input  logic       counter_rst,
   input  logic       counter_hold,
   output logic [3:0] count
);

   localparam logic [3:0] CNT_MAX = 4'(N_ITER);

   always_ff @(posedge clka) begin
      if (reset) begin
         count <= '0;
      end else if (counter_rst) begin
         count <= '0;
      end else if (counter_hold) begin
         count <= count;
      end else if (count < CNT_MAX) begin
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/cordic_datapath.sv
// Iterative CORDIC x/y/z datapath: one micro-rotation per clock under FSM control.
// Gain is not compensated here; callers prescale x by ~0.607253.
module cordic_datapath
   import cordic_pkg::*;
#(
   parameter int W      = CORDIC_W,
   parameter int N_ITER = CORDIC_N_ITER
) (
   input  logic                clka,
   input  logic                reset,
   input  logic                cordic_mode,
   input  logic [1:0]          in_mux_ctl,
   input  logic                counter_rst,
   input  logic                counter_hold,
   input  logic signed [W-1:0] x_in,
   input  logic signed [W-1:0] y_in,
   input  logic signed [W-1:0] z_in,
   output logic [3:0]          counter,
   output logic signed [W-1:0] x_out,
   output logic signed [W-1:0] y_out,
   output logic signed [W-1:0] z_out
);

   logic signed [W-1:0] x_reg, y_reg, z_reg;
   logic signed [W-1:0] x_next, y_next, z_next;
   logic signed [W-1:0] x_shift, y_shift, atan_step;
   logic [63:0]         atan_wide;
   logic [3:0]          count;
   logic [2:0]          iter_idx;
   logic                iter_active;
   logic                d_pos;

   cordic_iter_counter #(
      .N_ITER (N_ITER)
   ) u_iter_counter (
      .clka         (clka),
      .reset        (reset),
      .counter_rst  (counter_rst),
      .counter_hold (counter_hold),
      .count        (count)
   );

   assign iter_idx    = count[2:0];
   assign iter_active = (count < 4'(N_ITER));

   // Rescale the Q2.14 table to this instance's Q2.(W-2) format.
   assign atan_wide = (64'(cordic_atan(iter_idx)) << W) >> 16;
   assign atan_step = W'(atan_wide);

   assign x_shift = x_reg >>> iter_idx;
   assign y_shift = y_reg >>> iter_idx;

   // Rotation steers z toward 0, vectoring steers y toward 0.
   assign d_pos = cordic_mode ? y_reg[W-1] : ~z_reg[W-1];

   always_comb begin
      x_next = x_reg;
      y_next = y_reg;
      z_next = z_reg;
      if (d_pos) begin
         x_next = x_reg - y_shift;
         y_next = y_reg + x_shift;
         z_next = z_reg - atan_step;
      end else begin
         x_next = x_reg + y_shift;
         y_next = y_reg - x_shift;
         z_next = z_reg + atan_step;
      end
   end

   always_ff @(posedge clka) begin
      if (reset) begin
         x_reg <= '0;
         y_reg <= '0;
         z_reg <= '0;
      end else begin
         case (in_mux_ctl)
            MUX_LOAD: begin
               x_reg <= x_in;
               y_reg <= y_in;
               z_reg <= z_in;
            end
            MUX_CLR: begin
               x_reg <= '0;
               y_reg <= '0;
               z_reg <= '0;
            end
            MUX_ITER: begin
               // Past the last iteration this degenerates to a hold.
               if (iter_active) begin
                  x_reg <= x_next;
                  y_reg <= y_next;
                  z_reg <= z_next;
               end
            end
            default: begin
               x_reg <= x_reg;
               y_reg <= y_reg;
               z_reg <= z_reg;
            end
         endcase
      end
   end

   assign counter = count;
   assign x_out   = x_reg;
   assign y_out   = y_reg;
   assign z_out   = z_reg;

endmodule
